// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: applies count bits 8/4/2/1 MSB-first, one stage per
// cycle, to a working register and returns the result on a valid/ready handshake.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       op,
  input  logic [3:0]       cnt,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StStage,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpRor = 2'b01,
    OpSrl = 2'b10,
    OpRol = 2'b11
  } op_e;

  state_e           state_q, state_d;
  logic [1:0]       stage_q, stage_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             lower_zero;

  // One stage of the old barrel chain: shift/rotate by 2^k.
  function automatic logic [WIDTH-1:0] apply_stage(input logic [WIDTH-1:0] w,
                                                   input logic [1:0]       o,
                                                   input logic [1:0]       k);
    logic [WIDTH-1:0] r;
    int unsigned      n;
    r = w;
    n = 32'd1 << k;
    unique case (op_e'(o))
      OpSll:   r = w << n;
      OpSrl:   r = w >> n;
      OpRor:   r = (w >> n) | (w << (WIDTH - n));
      OpRol:   r = (w << n) | (w >> (WIDTH - n));
      default: r = w;
    endcase
    return r;
  endfunction

  // True when no count bits remain below the current stage.
  always_comb begin
    lower_zero = 1'b1;
    unique case (stage_q)
      2'd3:    lower_zero = (cnt_q[2:0] == 3'd0);
      2'd2:    lower_zero = (cnt_q[1:0] == 2'd0);
      2'd1:    lower_zero = ~cnt_q[0];
      default: lower_zero = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = in_data;
          op_d    = op;
          cnt_d   = cnt;
          stage_d = 2'd3;
          state_d = (EARLY_EXIT && (cnt == 4'd0)) ? StDone : StStage;
        end
      end
      StStage: begin
        if (cnt_q[stage_q]) begin
          work_d = apply_stage(work_q, op_q, stage_q);
        end
        if ((stage_q == 2'd0) || (EARLY_EXIT && lower_zero)) begin
          state_d = StDone;
        end else begin
          stage_d = stage_q - 2'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stage_q <= 2'd0;
      work_q  <= '0;
      op_q    <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StStage);
  assign out_valid = (state_q == StDone);
  assign out_data  = work_q;

endmodule
